ps2_frame_receiver: RTL

- Upstream stage of keyboardHandler. Deserialises raw PS/2 device frames into bytes: make codes, E0/F0 prefixes and break codes.
- Validates start, parity and stop bits and queues good bytes in a small FIFO.
- Presents bytes through the data/ready/nextdata_n handshake that keyboardHandler already consumes.
- Receive-only: never drives PS2_CLK or PS2_DAT.

---
 rtl/ps2_frame_receiver_if.sv | 31 +++
 rtl/ps2_frame_receiver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver_if.sv
// ps2_frame_receiver_if
//   Bundles the PS/2 pins and the byte handshake toward keyboardHandler.
//   master : the PS/2 device side plus the byte consumer (drives pins and
//            nextdata_n, observes the byte outputs).
//   slave  : the receiver itself.
//   Signals:
//     ps2_clk, ps2_data : raw PS/2 pins, asynchronous to clk
//     nextdata_n        : active-low pop request, one cycle per byte
//     data              : FIFO head byte, valid while ready=1
//     ready             : FIFO non-empty
//     overflow          : sticky, a good frame was dropped on a full FIFO
//     parity_err        : one-cycle pulse, frame rejected (parity/stop)
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    modport master (
        output ps2_clk, ps2_data, nextdata_n,
        input  data, ready, overflow, parity_err
    );

    modport slave (
        input  ps2_clk, ps2_data, nextdata_n,
        output data, ready, overflow, parity_err
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Receive-only PS/2 deserialiser feeding keyboardHandler. Synchronises the
//   raw pins, assembles 11-bit frames (start, 8 data LSB first, odd parity,
//   stop), queues good bytes in a 2^ADDR_W deep FIFO and presents them via
//   the data/ready/nextdata_n handshake.
//   Ports:
//     clk  : system clock
//     clr  : synchronous active-high reset
//     bus  : ps2_frame_receiver_if.slave (pins, handshake, status)
//   Parameters:
//     ADDR_W  : log2 of FIFO depth
//     TIMEOUT : clk cycles without a PS/2 falling edge before a partial
//               frame is abandoned
module ps2_frame_receiver #(
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  clr,
    ps2_frame_receiver_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // ------------------------------------------------------------------
    // Pin synchronisers. The clock pin needs three stages so that the
    // edge detector compares two already-settled stages. The data sample
    // is taken from stage 1, so a third data stage would never be read
    // and is left out; the sample still lines up with the clock edge.
    // ------------------------------------------------------------------
    logic [2:0] sclk_q;
    logic [1:0] sdat_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            sclk_q <= 3'b111;
            sdat_q <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.ps2_clk};
            sdat_q <= {sdat_q[0], bus.ps2_data};
        end
    end

    logic fe;
    logic bit_s;
    assign fe    = sclk_q[2] & ~sclk_q[1];
    assign bit_s = sdat_q[1];

    // ------------------------------------------------------------------
    // Frame assembly. cnt_q: 0 = waiting for start, 1..8 = data bits,
    // 9 = parity, 10 = stop. Everything advances on fe only.
    // ------------------------------------------------------------------
    logic [3:0]    cnt_q;
    logic [7:0]    sr_q;
    logic          par_q;
    logic [TW-1:0] tcnt_q;

    logic stop_fe;
    logic good;
    assign stop_fe = fe && (cnt_q == 4'd10);
    // odd parity over data+parity, and the stop bit must be high
    assign good    = bit_s && (((^sr_q) ^ par_q) == 1'b1);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q  <= 4'd0;
            sr_q   <= 8'h00;
            par_q  <= 1'b0;
            tcnt_q <= '0;
        end else if (fe) begin
            tcnt_q <= '0;
            case (cnt_q)
                4'd0: begin
                    // a high sample here is a glitch, not a start bit
                    if (!bit_s) cnt_q <= 4'd1;
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                    // shift in from the top: after 8 bits the first bit is sr_q[0]
                    sr_q  <= {bit_s, sr_q[7:1]};
                    cnt_q <= cnt_q + 4'd1;
                end
                4'd9: begin
                    par_q <= bit_s;
                    cnt_q <= 4'd10;
                end
                default: cnt_q <= 4'd0;
            endcase
        end else if (cnt_q != 4'd0) begin
            // mid-frame with no clock edge: give up after TIMEOUT cycles
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                cnt_q  <= 4'd0;
                tcnt_q <= '0;
            end else begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO with one extra pointer bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [ADDR_W:0] w_ptr_q, r_ptr_q;
    logic [ADDR_W:0] w_ptr_d, r_ptr_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q;
    logic          ovf_q;
    logic          perr_q;

    logic full;
    logic pop;
    logic wr_en;
    logic drop_full;
    logic bad;

    assign full = (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]) &&
                  (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]);
    // ready_q mirrors non-empty, so a pop request on an empty FIFO is ignored
    assign pop       = ~bus.nextdata_n & ready_q;
    // a pop in the same cycle frees the slot the write needs
    assign wr_en     = stop_fe & good & (~full | pop);
    assign drop_full = stop_fe & good & full & ~pop;
    assign bad       = stop_fe & ~good;

    assign w_ptr_d = w_ptr_q + (ADDR_W + 1)'(wr_en);
    assign r_ptr_d = r_ptr_q + (ADDR_W + 1)'(pop);

    // Head byte after this edge. When the new head is the slot being
    // written right now (FIFO was empty), forward the incoming byte.
    always_comb begin
        data_d = mem_q[r_ptr_d[ADDR_W-1:0]];
        if (wr_en && (w_ptr_q[ADDR_W-1:0] == r_ptr_d[ADDR_W-1:0]))
            data_d = sr_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[w_ptr_q[ADDR_W-1:0]] <= sr_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            data_q  <= data_d;
            ready_q <= (w_ptr_d != r_ptr_d);
            if (drop_full) ovf_q <= 1'b1;
            perr_q  <= bad;
        end
    end

    assign bus.data       = data_q;
    assign bus.ready      = ready_q;
    assign bus.overflow   = ovf_q;
    assign bus.parity_err = perr_q;

endmodule
